// File: rtl/up_down_counter_ranged_if.sv
// Control and status bundle for up_down_counter_ranged.
// The master drives the control inputs and the slave (the counter) drives the status outputs.
interface up_down_counter_ranged_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             set;
    logic [WIDTH-1:0] set_value;
    logic             up_down;
    logic             saturate;
    logic             clear_flags;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_min;
    logic             wrap_pulse;
    logic             ovf_sticky;
    logic             unf_sticky;

    modport master (
        output enable, set, set_value, up_down, saturate, clear_flags,
        input  count, at_max, at_min, wrap_pulse, ovf_sticky, unf_sticky
    );

    modport slave (
        input  enable, set, set_value, up_down, saturate, clear_flags,
        output count, at_max, at_min, wrap_pulse, ovf_sticky, unf_sticky
    );
endinterface

// File: rtl/up_down_counter_ranged.sv
// Ranged up/down counter with wrap/saturate limits, clamped load and sticky flags.
// Optional prescaler is compiled in with the COUNTER_PRESCALE_EN macro.
module up_down_counter_ranged #(
    parameter int WIDTH     = 4,
    parameter int MIN_VALUE = 0,
    parameter int MAX_VALUE = (1 << WIDTH) - 1,
    parameter int PRESCALE  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    up_down_counter_ranged_if.slave  bus
);
    // Limits are held one bit wider so comparisons never alias through modulo-2^WIDTH.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VALUE);
    localparam logic [WIDTH:0]   MIN_EXT = (WIDTH+1)'(MIN_VALUE);
    localparam logic [WIDTH-1:0] MAX_CNT = MAX_EXT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MIN_CNT = MIN_EXT[WIDTH-1:0];

    logic [WIDTH-1:0] count_reg, count_next;
    logic             wrap_reg, wrap_next;
    logic             ovf_reg, ovf_next;
    logic             unf_reg, unf_next;
    logic             step_tick;
    logic             step;

    logic [WIDTH:0]   count_ext;
    logic [WIDTH:0]   set_ext;
    logic [WIDTH:0]   inc_ext;
    logic [WIDTH:0]   dec_ext;
    logic             at_max_int;
    logic             at_min_int;

`ifdef COUNTER_PRESCALE_EN
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] prescale_reg, prescale_next;

    assign step_tick = (prescale_reg == PS_LAST);

    always_comb begin
        prescale_next = prescale_reg;
        if (bus.set) begin
            prescale_next = '0;
        end else if (bus.enable) begin
            prescale_next = step_tick ? '0 : prescale_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_reg <= '0;
        end else begin
            prescale_reg <= prescale_next;
        end
    end
`else
    // Without the prescaler every qualified cycle is a step; PRESCALE is only checked for sanity.
    assign step_tick = (PRESCALE >= 1);
`endif

    assign count_ext  = {1'b0, count_reg};
    assign set_ext    = {1'b0, bus.set_value};
    assign inc_ext    = count_ext + 1'b1;
    assign dec_ext    = count_ext - 1'b1;
    assign at_max_int = (count_reg == MAX_CNT);
    assign at_min_int = (count_reg == MIN_CNT);
    assign step       = bus.enable && !bus.set && step_tick;

    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        ovf_next   = bus.clear_flags ? 1'b0 : ovf_reg;
        unf_next   = bus.clear_flags ? 1'b0 : unf_reg;
        if (bus.set) begin
            if (set_ext > MAX_EXT) begin
                count_next = MAX_CNT;
            end else if (set_ext < MIN_EXT) begin
                count_next = MIN_CNT;
            end else begin
                count_next = bus.set_value;
            end
        end else if (step) begin
            if (bus.up_down) begin
                if (at_max_int) begin
                    ovf_next = 1'b1;
                    if (!bus.saturate) begin
                        count_next = MIN_CNT;
                        wrap_next  = 1'b1;
                    end
                end else begin
                    count_next = inc_ext[WIDTH-1:0];
                end
            end else begin
                if (at_min_int) begin
                    unf_next = 1'b1;
                    if (!bus.saturate) begin
                        count_next = MAX_CNT;
                        wrap_next  = 1'b1;
                    end
                end else begin
                    count_next = dec_ext[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= MIN_CNT;
            wrap_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
            ovf_reg   <= ovf_next;
            unf_reg   <= unf_next;
        end
    end

    assign bus.count      = count_reg;
    assign bus.at_max     = at_max_int;
    assign bus.at_min     = at_min_int;
    assign bus.wrap_pulse = wrap_reg;
    assign bus.ovf_sticky = ovf_reg;
    assign bus.unf_sticky = unf_reg;
endmodule

// File: tb/tb_up_down_counter_ranged.sv
// Directed self-checking bench: full-range counter, 2..9 sub-range counter and,
// when COUNTER_PRESCALE_EN is defined, a PRESCALE=4 counter.
module tb_up_down_counter_ranged;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    up_down_counter_ranged_if #(.WIDTH(4)) bus_a ();
    up_down_counter_ranged_if #(.WIDTH(4)) bus_b ();

    up_down_counter_ranged #(.WIDTH(4), .MIN_VALUE(0), .MAX_VALUE(15), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    up_down_counter_ranged #(.WIDTH(4), .MIN_VALUE(2), .MAX_VALUE(9), .PRESCALE(1)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

`ifdef COUNTER_PRESCALE_EN
    up_down_counter_ranged_if #(.WIDTH(4)) bus_c ();
    up_down_counter_ranged #(.WIDTH(4), .MIN_VALUE(0), .MAX_VALUE(15), .PRESCALE(4)) dut_c (
        .clk(clk), .reset(reset), .bus(bus_c.slave));
`endif

    // Inputs change 2 ns after an edge; outputs are read at the same point.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_a();
        bus_a.enable = 0; bus_a.set = 0; bus_a.set_value = 0;
        bus_a.up_down = 0; bus_a.saturate = 0; bus_a.clear_flags = 0;
    endtask

    task automatic idle_b();
        bus_b.enable = 0; bus_b.set = 0; bus_b.set_value = 0;
        bus_b.up_down = 0; bus_b.saturate = 0; bus_b.clear_flags = 0;
    endtask

    task automatic test_reset();
        reset = 1; tick(); reset = 0;
        n_cmp++; if (bus_a.count !== 4'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", bus_a.count); end
        n_cmp++; if (bus_a.at_min !== 1'b1) begin n_err++; $display("FAIL rst_at_min: got %0b want 1", bus_a.at_min); end
        n_cmp++; if (bus_a.at_max !== 1'b0) begin n_err++; $display("FAIL rst_at_max: got %0b want 0", bus_a.at_max); end
        n_cmp++; if (bus_a.wrap_pulse !== 1'b0) begin n_err++; $display("FAIL rst_wrap: got %0b want 0", bus_a.wrap_pulse); end
        n_cmp++; if (bus_a.ovf_sticky !== 1'b0 || bus_a.unf_sticky !== 1'b0) begin n_err++; $display("FAIL rst_flags: got ovf=%0b unf=%0b want 0/0", bus_a.ovf_sticky, bus_a.unf_sticky); end
        n_cmp++; if (bus_b.count !== 4'd2) begin n_err++; $display("FAIL rst_sub_count: got %0d want 2", bus_b.count); end
        $display("reset: count_a=%0d count_b=%0d", bus_a.count, bus_b.count);
    endtask

    task automatic test_basic();
        bus_a.set = 1; bus_a.set_value = 4'd3; tick(); bus_a.set = 0;
        n_cmp++; if (bus_a.count !== 4'd3) begin n_err++; $display("FAIL basic_load: got %0d want 3", bus_a.count); end
        bus_a.enable = 1; bus_a.up_down = 0; tick();
        n_cmp++; if (bus_a.count !== 4'd2) begin n_err++; $display("FAIL basic_down: got %0d want 2", bus_a.count); end
        bus_a.up_down = 1; tick();
        n_cmp++; if (bus_a.count !== 4'd3) begin n_err++; $display("FAIL basic_up: got %0d want 3", bus_a.count); end
        idle_a();
        $display("basic: load 3, down, up -> count=%0d", bus_a.count);
    endtask

    task automatic test_wrap_up();
        bus_a.set = 1; bus_a.set_value = 4'd15; tick(); bus_a.set = 0;
        n_cmp++; if (bus_a.at_max !== 1'b1) begin n_err++; $display("FAIL wrap_at_max: got %0b want 1", bus_a.at_max); end
        bus_a.enable = 1; bus_a.up_down = 1; bus_a.saturate = 0; tick();
        n_cmp++; if (bus_a.count !== 4'd0) begin n_err++; $display("FAIL wrap_count: got %0d want 0", bus_a.count); end
        n_cmp++; if (bus_a.wrap_pulse !== 1'b1) begin n_err++; $display("FAIL wrap_pulse: got %0b want 1", bus_a.wrap_pulse); end
        n_cmp++; if (bus_a.ovf_sticky !== 1'b1) begin n_err++; $display("FAIL wrap_ovf: got %0b want 1", bus_a.ovf_sticky); end
        tick();
        n_cmp++; if (bus_a.count !== 4'd1) begin n_err++; $display("FAIL wrap_next_count: got %0d want 1", bus_a.count); end
        n_cmp++; if (bus_a.wrap_pulse !== 1'b0) begin n_err++; $display("FAIL wrap_pulse_drop: got %0b want 0", bus_a.wrap_pulse); end
        idle_a();
        $display("wrap_up: 15 -> 0 -> count=%0d ovf=%0b", bus_a.count, bus_a.ovf_sticky);
    endtask

    task automatic test_saturate_down();
        bus_a.set = 1; bus_a.set_value = 4'd0; tick(); bus_a.set = 0;
        bus_a.saturate = 1; bus_a.up_down = 0; bus_a.enable = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus_a.count !== 4'd0) begin n_err++; $display("FAIL sat_count[%0d]: got %0d want 0", i, bus_a.count); end
            n_cmp++; if (bus_a.wrap_pulse !== 1'b0) begin n_err++; $display("FAIL sat_wrap[%0d]: got %0b want 0", i, bus_a.wrap_pulse); end
        end
        n_cmp++; if (bus_a.unf_sticky !== 1'b1) begin n_err++; $display("FAIL sat_unf: got %0b want 1", bus_a.unf_sticky); end
        n_cmp++; if (bus_a.ovf_sticky !== 1'b1) begin n_err++; $display("FAIL sat_ovf_held: got %0b want 1", bus_a.ovf_sticky); end
        idle_a();
        $display("saturate_down: count=%0d unf=%0b", bus_a.count, bus_a.unf_sticky);
    endtask

    task automatic test_sub_range();
        bus_b.set = 1; bus_b.set_value = 4'd12; tick();
        n_cmp++; if (bus_b.count !== 4'd9) begin n_err++; $display("FAIL sub_clamp_hi: got %0d want 9", bus_b.count); end
        n_cmp++; if (bus_b.at_max !== 1'b1) begin n_err++; $display("FAIL sub_at_max: got %0b want 1", bus_b.at_max); end
        bus_b.set_value = 4'd1; tick();
        n_cmp++; if (bus_b.count !== 4'd2) begin n_err++; $display("FAIL sub_clamp_lo: got %0d want 2", bus_b.count); end
        n_cmp++; if (bus_b.at_min !== 1'b1) begin n_err++; $display("FAIL sub_at_min: got %0b want 1", bus_b.at_min); end
        bus_b.set_value = 4'd9; tick(); bus_b.set = 0;
        bus_b.enable = 1; bus_b.up_down = 1; bus_b.saturate = 0; tick();
        n_cmp++; if (bus_b.count !== 4'd2) begin n_err++; $display("FAIL sub_wrap_up: got %0d want 2", bus_b.count); end
        n_cmp++; if (bus_b.wrap_pulse !== 1'b1) begin n_err++; $display("FAIL sub_wrap_pulse: got %0b want 1", bus_b.wrap_pulse); end
        bus_b.up_down = 0; tick();
        n_cmp++; if (bus_b.count !== 4'd9) begin n_err++; $display("FAIL sub_wrap_down: got %0d want 9", bus_b.count); end
        n_cmp++; if (bus_b.wrap_pulse !== 1'b1) begin n_err++; $display("FAIL sub_wrap_pulse2: got %0b want 1", bus_b.wrap_pulse); end
        n_cmp++; if (bus_b.unf_sticky !== 1'b1) begin n_err++; $display("FAIL sub_unf: got %0b want 1", bus_b.unf_sticky); end
        bus_b.enable = 0; bus_b.set = 1; bus_b.set_value = 4'd5; tick();
        n_cmp++; if (bus_b.wrap_pulse !== 1'b0) begin n_err++; $display("FAIL sub_load_wrap: got %0b want 0", bus_b.wrap_pulse); end
        n_cmp++; if (bus_b.count !== 4'd5) begin n_err++; $display("FAIL sub_load5: got %0d want 5", bus_b.count); end
        idle_b();
        $display("sub_range: count=%0d", bus_b.count);
    endtask

    task automatic test_flag_priority();
        bus_a.clear_flags = 1; tick(); bus_a.clear_flags = 0;
        n_cmp++; if (bus_a.ovf_sticky !== 1'b0) begin n_err++; $display("FAIL clr_ovf: got %0b want 0", bus_a.ovf_sticky); end
        n_cmp++; if (bus_a.unf_sticky !== 1'b0) begin n_err++; $display("FAIL clr_unf: got %0b want 0", bus_a.unf_sticky); end
        bus_a.set = 1; bus_a.set_value = 4'd15; tick(); bus_a.set = 0;
        bus_a.clear_flags = 1; bus_a.enable = 1; bus_a.up_down = 1; bus_a.saturate = 1; tick();
        n_cmp++; if (bus_a.ovf_sticky !== 1'b1) begin n_err++; $display("FAIL clr_vs_ovf: got %0b want 1", bus_a.ovf_sticky); end
        n_cmp++; if (bus_a.count !== 4'd15) begin n_err++; $display("FAIL sat_up_hold: got %0d want 15", bus_a.count); end
        bus_a.enable = 0; tick();
        n_cmp++; if (bus_a.ovf_sticky !== 1'b0) begin n_err++; $display("FAIL clr_ovf2: got %0b want 0", bus_a.ovf_sticky); end
        bus_a.clear_flags = 0; bus_a.set = 1; bus_a.set_value = 4'd0; tick(); bus_a.set = 0;
        bus_a.clear_flags = 1; bus_a.enable = 1; bus_a.up_down = 0; tick();
        n_cmp++; if (bus_a.unf_sticky !== 1'b1) begin n_err++; $display("FAIL clr_vs_unf: got %0b want 1", bus_a.unf_sticky); end
        idle_a();
        $display("flag_priority: ovf=%0b unf=%0b", bus_a.ovf_sticky, bus_a.unf_sticky);
    endtask

    task automatic test_reset_override();
        bus_a.set = 1; bus_a.set_value = 4'd7; tick();
        bus_a.enable = 1; bus_a.up_down = 1; bus_a.clear_flags = 1; reset = 1; tick(); reset = 0;
        n_cmp++; if (bus_a.count !== 4'd0) begin n_err++; $display("FAIL rst_over_count: got %0d want 0", bus_a.count); end
        n_cmp++; if (bus_a.unf_sticky !== 1'b0) begin n_err++; $display("FAIL rst_over_unf: got %0b want 0", bus_a.unf_sticky); end
        idle_a();
        $display("reset_override: count=%0d", bus_a.count);
    endtask

`ifdef COUNTER_PRESCALE_EN
    task automatic test_prescale();
        bus_c.enable = 0; bus_c.set = 0; bus_c.set_value = 0;
        bus_c.up_down = 1; bus_c.saturate = 0; bus_c.clear_flags = 0;
        reset = 1; tick(); reset = 0;
        bus_c.enable = 1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_cmp++; if (bus_c.count !== 4'(i / 4)) begin n_err++; $display("FAIL ps_count[%0d]: got %0d want %0d", i, bus_c.count, i / 4); end
        end
        tick(); tick();
        bus_c.enable = 0; bus_c.set = 1; bus_c.set_value = 4'd5; tick(); bus_c.set = 0;
        bus_c.enable = 1;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (bus_c.count !== 4'd5) begin n_err++; $display("FAIL ps_after3: got %0d want 5", bus_c.count); end
        tick();
        n_cmp++; if (bus_c.count !== 4'd6) begin n_err++; $display("FAIL ps_after4: got %0d want 6", bus_c.count); end
        bus_c.enable = 0;
        $display("prescale: count=%0d", bus_c.count);
    endtask
`endif

    initial begin
        reset = 0;
        idle_a();
        idle_b();
        test_reset();
        test_basic();
        test_wrap_up();
        test_saturate_down();
        test_sub_range();
        test_flag_priority();
        test_reset_override();
`ifdef COUNTER_PRESCALE_EN
        test_prescale();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/up_down_counter_ranged.md
# up_down_counter_ranged

Parametrised up/down counter with a programmable range and selectable wrap or saturate behaviour at the range limits. It provides synchronous load, limit flags, a wrap pulse and sticky overflow/underflow flags. It generalises the fixed 4-bit up/down counter and is the standard counting primitive for timers, pointers and event tallies across the design.

## Interface
- WIDTH, 4: counter width in bits.
- MIN_VALUE, 0: lower range limit.
- MAX_VALUE, (1<<WIDTH)-1: upper range limit; must satisfy MIN_VALUE < MAX_VALUE <= 2^WIDTH-1.
- PRESCALE, 4: qualified enables per step; used only with COUNTER_PRESCALE_EN; must be >= 1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  count qualifier.
- set  in  1  load request.
- set_value  in  WIDTH  load value.
- up_down  in  1  direction: 1 = up, 0 = down.
- saturate  in  1  limit mode: 1 = saturate at limits, 0 = wrap.
- clear_flags  in  1  clears the sticky flags.
- count  out  WIDTH  registered count.
- at_max  out  1  count == MAX_VALUE, decoded from the count register.
- at_min  out  1  count == MIN_VALUE, decoded from the count register.
- wrap_pulse  out  1  registered; high for the one cycle following a wrap.
- ovf_sticky  out  1  set by an up step taken while at MAX_VALUE.
- unf_sticky  out  1  set by a down step taken while at MIN_VALUE.

## Operation
- Priority each cycle: reset, then set, then step.
- Reset: count=MIN_VALUE, wrap_pulse=0, ovf_sticky=0, unf_sticky=0, prescaler=0. This gives at_min=1 and at_max=0.
- Set: load set_value clamped to the range. A value above MAX_VALUE loads MAX_VALUE; a value below MIN_VALUE loads MIN_VALUE. Set suppresses any step in the same cycle and clears the prescaler.
- A step occurs when enable=1 and set=0 (and the prescaler terminal condition holds, if prescaling is compiled in).
- Up step, count < MAX_VALUE: count+1.
- Up step, count == MAX_VALUE:
  - wrap mode: count becomes MIN_VALUE, wrap_pulse=1, ovf_sticky=1.
  - saturate mode: count holds, ovf_sticky=1, no wrap pulse.
- Down step: mirror of the up step, using MIN_VALUE, MAX_VALUE and unf_sticky.
- wrap_pulse is 0 in every cycle without a wrap, including load cycles.
- Sticky flags hold until clear_flags or reset. If an event and clear_flags occur in the same cycle, the event wins and the flag remains set.
- The saturate and up_down inputs are sampled each cycle and may change on any cycle without corrupting state.
- Arithmetic is performed at WIDTH+1 bits internally; no silent modulo-2^WIDTH wrap is permitted when the range is a sub-range.

## Timing
- Inputs are sampled on the rising edge of clk. count, wrap_pulse and the sticky flags update at that same edge, giving a latency of one cycle.
- at_max and at_min follow count combinationally, with no additional latency.
- Reset asserted mid-count takes effect at the next edge and overrides a simultaneous set, enable or clear_flags.
- wrap_pulse is asserted for exactly one cycle per wrap. Consecutive wraps (possible when MAX_VALUE-MIN_VALUE is small) produce one pulse each.

## Configuration
- COUNTER_PRESCALE_EN defined:
  - An internal prescaler of clog2(PRESCALE) bits advances on each cycle with enable=1 and set=0.
  - A step occurs only on the cycle where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - enable=0 holds the prescaler. A direction change does not clear it.
  - PRESCALE=1 is equivalent to the macro being undefined.
- COUNTER_PRESCALE_EN undefined: every cycle with enable=1 and set=0 is a step. PRESCALE is ignored and no prescaler logic is instantiated.

## Test plan
- Defaults (WIDTH=4, MIN=0, MAX=15), clock period 10 ns:
  - Stimulus: reset for one edge; set=1 with set_value=3; then enable=1, up_down=0 for one edge; then up_down=1 for one edge.
  - Required: count reads 0, then 3, then 2, then 3. at_min=1 after reset.
- Wrap up, defaults:
  - Stimulus: load 15; enable=1, up_down=1, saturate=0 for one edge.
  - Required: count=0, wrap_pulse=1 for exactly one cycle, ovf_sticky=1. A second edge gives count=1 and wrap_pulse=0.
- Saturate down, defaults:
  - Stimulus: load 0; saturate=1, up_down=0, enable=1 for 3 edges.
  - Required: count stays 0, unf_sticky=1, wrap_pulse stays 0.
- Sub-range (MIN=2, MAX=9):
  - Stimulus: load 12, then load 1; then load 9 and step up with saturate=0.
  - Required: 12 loads as 9 with at_max=1; 1 loads as 2; the step from 9 gives 2 with wrap_pulse=1.
- Flag priority:
  - Stimulus: set ovf_sticky; pulse clear_flags alone; then apply clear_flags in the same cycle as an overflow step.
  - Required: clear_flags alone gives ovf_sticky=0. Clear with simultaneous overflow leaves ovf_sticky=1.
- Prescaler (COUNTER_PRESCALE_EN, PRESCALE=4), starting from count 0:
  - Stimulus: enable=1, up_down=1 for 8 edges. Then, from count 2, apply 2 enabled edges, a set of 5, and 4 more enabled edges.
  - Required: count=2 after the first 8 edges. The final sequence ends at count=6, showing set cleared the prescaler.
